// File: rtl/machine_timer_irq_src.sv
// -----------------------------------------------------------------------------
// machine_timer_irq_src
//   Memory-mapped RISC-V machine timer with 64-bit mtime/mtimecmp. It raises
//   timer_timeout_o for the main control FSM. Counting is gated by both the
//   CTRL.EN bit and enable_design_i. The pending flag stays set until an MRET
//   (irq_ack_i) or a write-1-to-clear of CTRL.PENDING.
//
// Register map (word address):
//   0 MTIME_LO   1 MTIME_HI   2 CMP_LO   3 CMP_HI
//   4 CTRL {bit0 EN, bit1 AUTO_RELOAD, bit2 PENDING (RO, W1C)}
//   5 PRESCALE   6-7 reserved (read 0, writes ignored)
//
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   enable_design_i  count gate from the main FSM
//   irq_ack_i        MRET retired; clears pending
//   wr_en_i, rd_en_i register write / read strobes
//   addr_i, wdata_i  register word address and write data
//   rdata_o          registered read data (valid the cycle after rd_en_i)
//   timer_timeout_o  pending timer interrupt (level)
//   mtime_o          current mtime
// -----------------------------------------------------------------------------
module machine_timer_irq_src #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PRESC_W   = 16,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable_design_i,
  input  logic            irq_ack_i,
  input  logic            wr_en_i,
  input  logic            rd_en_i,
  input  logic [2:0]      addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            timer_timeout_o,
  output logic [63:0]     mtime_o
);

  localparam int unsigned MTIME_W = 64;
  localparam int unsigned HALF_W  = 32;

  localparam logic [2:0] ADDR_MTIME_LO = 3'd0;
  localparam logic [2:0] ADDR_MTIME_HI = 3'd1;
  localparam logic [2:0] ADDR_CMP_LO   = 3'd2;
  localparam logic [2:0] ADDR_CMP_HI   = 3'd3;
  localparam logic [2:0] ADDR_CTRL     = 3'd4;
  localparam logic [2:0] ADDR_PRESC    = 3'd5;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_AUTO_BIT = 1;
  localparam int unsigned CTRL_PEND_BIT = 2;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIRED = 2'd2
  } state_e;

  // State registers
  state_e               state_q, state_d;
  logic [MTIME_W-1:0]   mtime_q, mtime_d;
  logic [MTIME_W-1:0]   cmp_q, cmp_d;
  logic                 en_q, en_d;
  logic                 auto_q, auto_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [PRESC_W-1:0]   pcnt_q, pcnt_d;
  logic [HALF_W-1:0]    shadow_q, shadow_d;
  logic [XLEN-1:0]      rdata_q, rdata_d;
  logic                 timeout_q, timeout_d;

  // Internal combinational signals
  logic ctrl_wr;
  logic w1c;
  logic count_en;
  logic tick;
  logic fire;

  // Write decode shared by the FSM and the datapath; en_d is the EN value
  // that will hold after this edge, so a combined W1C+EN write resolves
  // against the new EN.
  always_comb begin
    ctrl_wr = wr_en_i && (addr_i == ADDR_CTRL);
    w1c     = ctrl_wr && wdata_i[CTRL_PEND_BIT];
    en_d    = ctrl_wr ? wdata_i[CTRL_EN_BIT]   : en_q;
    auto_d  = ctrl_wr ? wdata_i[CTRL_AUTO_BIT] : auto_q;
  end

  // Prescaler: a tick is produced on the cycle the counter reaches PRESCALE.
  always_comb begin
    count_en = en_q && enable_design_i;
    tick     = count_en && (pcnt_q == presc_q);
  end

  // Timer FSM: next state and match detection.
  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (en_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en_q) begin
          state_d = ST_OFF;
        end else if (mtime_q >= cmp_q) begin
          state_d = ST_FIRED;
          fire    = 1'b1;
        end
      end
      ST_FIRED: begin
        // Only an ack or W1C leaves FIRED; dropping EN alone keeps it pending.
        if (irq_ack_i || w1c) state_d = en_d ? ST_RUN : ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
    timeout_d = (state_d == ST_FIRED);
  end

  // Datapath: counter, prescaler, compare and config registers.
  // Priority on mtime: software write > auto-reload > tick.
  always_comb begin
    mtime_d = mtime_q;
    pcnt_d  = pcnt_q;
    cmp_d   = cmp_q;
    presc_d = presc_q;

    if (count_en) pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
    if (tick)     mtime_d = mtime_q + MTIME_W'(1);

    if (fire && auto_q) begin
      mtime_d = '0;
      pcnt_d  = '0;
    end

    // A half write keeps the other half at its old value, with no carry.
    if (wr_en_i) begin
      case (addr_i)
        ADDR_MTIME_LO: mtime_d = {mtime_q[MTIME_W-1:HALF_W], wdata_i[HALF_W-1:0]};
        ADDR_MTIME_HI: mtime_d = {wdata_i[HALF_W-1:0], mtime_q[HALF_W-1:0]};
        ADDR_CMP_LO:   cmp_d   = {cmp_q[MTIME_W-1:HALF_W], wdata_i[HALF_W-1:0]};
        ADDR_CMP_HI:   cmp_d   = {wdata_i[HALF_W-1:0], cmp_q[HALF_W-1:0]};
        ADDR_PRESC:    presc_d = wdata_i[PRESC_W-1:0];
        default: ;
      endcase
    end
  end

  // Read path: values are taken before this cycle's writes. Reading
  // MTIME_LO snapshots the upper half so a LO-then-HI pair is coherent.
  always_comb begin
    rdata_d  = rdata_q;
    shadow_d = shadow_q;
    if (rd_en_i) begin
      case (addr_i)
        ADDR_MTIME_LO: begin
          rdata_d  = XLEN'(mtime_q[HALF_W-1:0]);
          shadow_d = mtime_q[MTIME_W-1:HALF_W];
        end
        ADDR_MTIME_HI: rdata_d = XLEN'(shadow_q);
        ADDR_CMP_LO:   rdata_d = XLEN'(cmp_q[HALF_W-1:0]);
        ADDR_CMP_HI:   rdata_d = XLEN'(cmp_q[MTIME_W-1:HALF_W]);
        ADDR_CTRL:     rdata_d = XLEN'({(state_q == ST_FIRED), auto_q, en_q});
        ADDR_PRESC:    rdata_d = XLEN'(presc_q);
        default:       rdata_d = '0;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_OFF;
      mtime_q   <= '0;
      cmp_q     <= CMP_RESET;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      shadow_q  <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mtime_q   <= mtime_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      auto_q    <= auto_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      shadow_q  <= shadow_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign rdata_o         = rdata_q;
  assign timer_timeout_o = timeout_q;
  assign mtime_o         = mtime_q;

endmodule

// File: tb/tb_machine_timer_irq_src.sv
// Bench for machine_timer_irq_src: a register-level model of the timer runs
// alongside the DUT and is compared on every falling edge; directed scenarios
// add hand-computed checkpoints that pin the model.
module tb_machine_timer_irq_src;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable_design_i;
  logic        irq_ack_i;
  logic        wr_en_i;
  logic        rd_en_i;
  logic [2:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        timer_timeout_o;
  logic [63:0] mtime_o;

  always #5 clk = ~clk;

  machine_timer_irq_src dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable_design_i (enable_design_i),
    .irq_ack_i       (irq_ack_i),
    .wr_en_i         (wr_en_i),
    .rd_en_i         (rd_en_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .rdata_o         (rdata_o),
    .timer_timeout_o (timer_timeout_o),
    .mtime_o         (mtime_o)
  );

  int total = 0;
  int bad   = 0;
  bit check_on = 1'b0;

  // Model state: "armed" means the timer is comparing (enabled, not pending).
  typedef struct packed {
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic        en;
    logic        arl;
    logic        pending;
    logic        armed;
    logic [15:0] presc;
    logic [15:0] pcnt;
    logic [31:0] shadow;
    logic [31:0] rdata;
  } model_t;

  model_t m;

  function automatic model_t step(input model_t s, input logic rst, input logic ena,
                                 input logic ack, input logic wr, input logic rd,
                                 input logic [2:0] a, input logic [31:0] d);
    model_t n;
    logic counting, tk, match;
    n = s;
    if (!rst) begin
      n = '0;
      n.cmp = 64'hFFFF_FFFF_FFFF_FFFF;
      return n;
    end
    if (rd) begin
      case (a)
        3'd0: begin n.rdata = s.mtime[31:0]; n.shadow = s.mtime[63:32]; end
        3'd1: n.rdata = s.shadow;
        3'd2: n.rdata = s.cmp[31:0];
        3'd3: n.rdata = s.cmp[63:32];
        3'd4: n.rdata = {29'd0, s.pending, s.arl, s.en};
        3'd5: n.rdata = {16'd0, s.presc};
        default: n.rdata = 32'd0;
      endcase
    end
    counting = s.en && ena;
    tk = counting && (s.pcnt == s.presc);
    if (counting) n.pcnt = tk ? 16'd0 : s.pcnt + 16'd1;
    if (tk) n.mtime = s.mtime + 64'd1;
    match = !s.pending && s.armed && s.en && (s.mtime >= s.cmp);
    if (match && s.arl) begin n.mtime = 64'd0; n.pcnt = 16'd0; end
    if (wr) begin
      case (a)
        3'd0: n.mtime = {s.mtime[63:32], d};
        3'd1: n.mtime = {d, s.mtime[31:0]};
        3'd2: n.cmp   = {s.cmp[63:32], d};
        3'd3: n.cmp   = {d, s.cmp[31:0]};
        3'd4: begin n.en = d[0]; n.arl = d[1]; end
        3'd5: n.presc = d[15:0];
        default: ;
      endcase
    end
    if (s.pending) begin
      if (ack || (wr && a == 3'd4 && d[2])) begin
        n.pending = 1'b0;
        n.armed   = n.en;
      end
    end else if (!s.armed) begin
      n.armed = s.en;
    end else if (!s.en) begin
      n.armed = 1'b0;
    end else if (match) begin
      n.pending = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk)
    m <= step(m, reset_n, enable_design_i, irq_ack_i, wr_en_i, rd_en_i, addr_i, wdata_i);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_on) begin
      check("model_timeout", 64'(timer_timeout_o), 64'(m.pending));
      check("model_mtime", mtime_o, m.mtime);
      check("model_rdata", 64'(rdata_o), 64'(m.rdata));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr_i = a; wdata_i = d; wr_en_i = 1'b1;
    cyc(1);
    wr_en_i = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] q);
    addr_i = a; rd_en_i = 1'b1;
    cyc(1);
    rd_en_i = 1'b0;
    q = rdata_o;
  endtask

  task automatic rw(input logic [2:0] a, input logic [31:0] d, output logic [31:0] q);
    addr_i = a; wdata_i = d; wr_en_i = 1'b1; rd_en_i = 1'b1;
    cyc(1);
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    q = rdata_o;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
  endtask

  logic [31:0] q;

  initial begin
    reset_n = 1'b0; enable_design_i = 1'b1; irq_ack_i = 1'b0;
    wr_en_i = 1'b0; rd_en_i = 1'b0; addr_i = 3'd0; wdata_i = 32'd0;
    cyc(1);
    check_on = 1'b1;
    cyc(1);
    reset_n = 1'b1;

    // Reset values of every register
    check("rst_timeout", 64'(timer_timeout_o), 64'd0);
    check("rst_mtime", mtime_o, 64'd0);
    rd(3'd0, q); check("rst_mtime_lo", 64'(q), 64'd0);
    rd(3'd1, q); check("rst_mtime_hi", 64'(q), 64'd0);
    rd(3'd2, q); check("rst_cmp_lo", 64'(q), 64'hFFFF_FFFF);
    rd(3'd3, q); check("rst_cmp_hi", 64'(q), 64'hFFFF_FFFF);
    rd(3'd4, q); check("rst_ctrl", 64'(q), 64'd0);
    rd(3'd5, q); check("rst_presc", 64'(q), 64'd0);

    // One-shot, CMP=5, no prescale
    wr(3'd2, 32'd5); wr(3'd3, 32'd0); wr(3'd4, 32'd1);
    cyc(5); check("os_mtime5", mtime_o, 64'd5); check("os_not_yet", 64'(timer_timeout_o), 64'd0);
    cyc(1); check("os_fired", 64'(timer_timeout_o), 64'd1); check("os_mtime6", mtime_o, 64'd6);
    cyc(3); check("os_sticky", 64'(timer_timeout_o), 64'd1);
    irq_ack_i = 1'b1; cyc(1); irq_ack_i = 1'b0;
    check("os_ack_low", 64'(timer_timeout_o), 64'd0);
    cyc(1); check("os_refire", 64'(timer_timeout_o), 64'd1);
    irq_ack_i = 1'b1; wr(3'd3, 32'd1); irq_ack_i = 1'b0;
    check("os_ack2_low", 64'(timer_timeout_o), 64'd0);
    cyc(3); check("os_no_refire", 64'(timer_timeout_o), 64'd0);
    irq_ack_i = 1'b1; cyc(1); irq_ack_i = 1'b0;
    cyc(1); check("os_ack_in_run", 64'(timer_timeout_o), 64'd0);

    // Prescaler 3, CMP=2
    do_reset();
    wr(3'd5, 32'd3); wr(3'd2, 32'd2); wr(3'd3, 32'd0); wr(3'd4, 32'd1);
    cyc(4); check("ps_mtime1", mtime_o, 64'd1);
    cyc(4); check("ps_mtime2", mtime_o, 64'd2); check("ps_not_yet", 64'(timer_timeout_o), 64'd0);
    cyc(1); check("ps_fired", 64'(timer_timeout_o), 64'd1);

    // Reset while FIRED
    reset_n = 1'b0; cyc(1);
    check("rf_timeout", 64'(timer_timeout_o), 64'd0);
    check("rf_mtime", mtime_o, 64'd0);
    reset_n = 1'b1;
    rd(3'd4, q); check("rf_ctrl", 64'(q), 64'd0);
    rd(3'd2, q); check("rf_cmp_lo", 64'(q), 64'hFFFF_FFFF);
    rd(3'd3, q); check("rf_cmp_hi", 64'(q), 64'hFFFF_FFFF);

    // Prescaler with enable_design_i low for 5 cycles: fire delayed by 5
    wr(3'd5, 32'd3); wr(3'd2, 32'd2); wr(3'd3, 32'd0); wr(3'd4, 32'd1);
    cyc(2); enable_design_i = 1'b0;
    cyc(5); check("fz_frozen", mtime_o, 64'd0);
    enable_design_i = 1'b1;
    cyc(6); check("fz_mtime2", mtime_o, 64'd2); check("fz_not_yet", 64'(timer_timeout_o), 64'd0);
    cyc(1); check("fz_fired", 64'(timer_timeout_o), 64'd1);

    // Auto-reload, CMP=3
    do_reset();
    wr(3'd2, 32'd3); wr(3'd3, 32'd0); wr(3'd4, 32'd3);
    cyc(3); check("ar_mtime3", mtime_o, 64'd3); check("ar_not_yet", 64'(timer_timeout_o), 64'd0);
    cyc(1); check("ar_reload", mtime_o, 64'd0); check("ar_fired", 64'(timer_timeout_o), 64'd1);
    rd(3'd4, q); check("ar_ctrl_pend", 64'(q), 64'd7); check("ar_counts", mtime_o, 64'd1);
    wr(3'd4, 32'd7); check("ar_w1c", 64'(timer_timeout_o), 64'd0); check("ar_mtime2", mtime_o, 64'd2);
    cyc(1); check("ar_mtime3b", mtime_o, 64'd3); check("ar_not_yet2", 64'(timer_timeout_o), 64'd0);
    cyc(1); check("ar_refire", 64'(timer_timeout_o), 64'd1); check("ar_reload2", mtime_o, 64'd0);

    // Carry into the upper half and the hi shadow
    do_reset();
    wr(3'd0, 32'hFFFF_FFFF); wr(3'd4, 32'd1); wr(3'd4, 32'd0);
    check("cy_mtime", mtime_o, 64'h0000_0001_0000_0000);
    rd(3'd0, q); check("cy_lo", 64'(q), 64'd0);
    wr(3'd1, 32'h0000_ABCD);
    rd(3'd1, q); check("cy_hi_shadow", 64'(q), 64'd1);
    check("cy_hi_written", mtime_o, 64'h0000_ABCD_0000_0000);
    rd(3'd0, q); rd(3'd1, q); check("cy_hi_new", 64'(q), 64'h0000_ABCD);

    // 64-bit wrap
    wr(3'd0, 32'hFFFF_FFFF); wr(3'd1, 32'hFFFF_FFFF); wr(3'd4, 32'd1);
    cyc(1); check("wrap_zero", mtime_o, 64'd0); check("wrap_no_fire", 64'(timer_timeout_o), 64'd0);
    wr(3'd4, 32'd0);

    // Reserved addresses and read-during-write
    wr(3'd6, 32'd123);
    rd(3'd6, q); check("rsv6", 64'(q), 64'd0);
    rd(3'd7, q); check("rsv7", 64'(q), 64'd0);
    rw(3'd5, 32'd7, q); check("rw_old", 64'(q), 64'd0);
    rd(3'd5, q); check("rw_new", 64'(q), 64'd7);

    cyc(3);
    check_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
